// File: rtl/pret_et.sv
// pret_et: progressive-precision stochastic-computing evaluator with start/done handshake.
// Streams deterministic operand/constant bitstreams, counts Z, and stops once the top P result bits are settled.
module pret_et #(
  parameter int W    = 6,
  parameter int N    = 2,
  parameter int NC   = 0,
  parameter int CORR = 0,
  localparam int TW  = (CORR != 0) ? (W + NC) : (W * N + NC),
  localparam int PW  = $clog2(TW + 1),
  localparam int NCW = (NC > 0) ? NC : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N-1:0][W-1:0] Bxs,
  input  logic [PW-1:0]       prec,
  output logic                busy,
  output logic [N-1:0]        Xs,
  output logic [NCW-1:0]      Xcs,
  input  logic                Z,
  output logic [TW:0]         Bz,
  output logic [TW:0]         cycles,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [PW-1:0] P_MAX   = PW'(TW);
  localparam logic [PW-1:0] P_MIN   = PW'(1);
  localparam logic [TW:0]   FULL    = {1'b1, {TW{1'b0}}};
  localparam logic [TW:0]   CYC_ONE = {{TW{1'b0}}, 1'b1};
  localparam logic [TW-1:0] CNT_ONE = TW'(1);
  localparam int            CBASE   = (CORR != 0) ? W : W * N;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N-1:0][W-1:0] r_bx;
  logic [PW-1:0]       r_p;
  logic [TW-1:0]       r_cnt;
  logic [TW:0]         r_bz;
  logic [TW:0]         r_cycles;

  logic                w_accept;
  logic [TW:0]         w_bz_nxt;
  logic [TW:0]         w_cyc_nxt;
  logic [TW:0]         w_rem;
  logic [TW:0]         w_hi;
  logic [PW-1:0]       w_s;
  logic                w_settled;
  logic [N-1:0][W-1:0] w_field;
  logic [N-1:0]        w_xs;
  logic [NCW-1:0]      w_xcs;

  function automatic logic [W-1:0] rev_w(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) r[b] = v[W-1-b];
    return r;
  endfunction

  function automatic logic [PW-1:0] clamp_prec(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = p;
    if (p == '0)
      r = P_MIN;
    else if (p > P_MAX)
      r = P_MAX;
    return r;
  endfunction

  // Termination test on the post-update count: the top P bits of c and c+R agree,
  // so no remaining samples can change them.
  assign w_bz_nxt  = r_bz + {{TW{1'b0}}, Z};
  assign w_cyc_nxt = r_cycles + CYC_ONE;
  assign w_rem     = FULL - w_cyc_nxt;
  assign w_hi      = w_bz_nxt + w_rem;
  assign w_s       = P_MAX - r_p;
  assign w_settled = (w_rem == '0) || ((w_bz_nxt >> w_s) == (w_hi >> w_s));
  assign w_accept  = start && (r_state != S_RUN);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_settled) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bx     <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_bz     <= '0;
      r_cycles <= '0;
    end else if (w_accept) begin
      r_bx     <= Bxs;
      r_p      <= clamp_prec(prec);
      r_cnt    <= '0;
      r_bz     <= '0;
      r_cycles <= '0;
    end else if (r_state == S_RUN) begin
      r_cnt    <= r_cnt + CNT_ONE;
      r_bz     <= w_bz_nxt;
      r_cycles <= w_cyc_nxt;
    end
  end

  // Correlated mode shares the low counter field across every operand.
  for (genvar gi = 0; gi < N; gi++) begin : g_field
    if (CORR != 0) begin : g_corr
      assign w_field[gi] = r_cnt[W-1:0];
    end else begin : g_ind
      assign w_field[gi] = r_cnt[gi*W +: W];
    end
  end

  always_comb begin
    w_xs = '0;
    if (r_state == S_RUN)
      for (int i = 0; i < N; i++) w_xs[i] = (r_bx[i] > rev_w(w_field[i]));
  end

  if (NC > 0) begin : g_xc
    assign w_xcs = (r_state == S_RUN) ? r_cnt[CBASE +: NCW] : '0;
  end else begin : g_noxc
    assign w_xcs = '0;
  end

  assign Xs     = w_xs;
  assign Xcs    = w_xcs;
  assign Bz     = r_bz;
  assign cycles = r_cycles;
  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);

endmodule

// File: tb/tb_pret_et.sv
// Bench for pret_et: per-cycle comparison of the independent-stream instance against a behavioural model,
// plus reference-run and literal checks for two correlated instances.
module tb_pret_et;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b1;

  // Instance A: CORR=0, NC=0, TW=12
  logic            startA = 1'b0;
  logic [1:0][5:0] bxA = '0;
  logic [3:0]      precA = '0;
  logic            busyA, doneA, zA;
  logic [1:0]      xsA;
  logic [0:0]      xcsA;
  logic [12:0]     bzA, cycA;
  assign zA = xsA[0] & xsA[1];

  pret_et #(.W(6), .N(2), .NC(0), .CORR(0)) dutA (
    .clk(clk), .rst(rst), .start(startA), .Bxs(bxA), .prec(precA), .busy(busyA),
    .Xs(xsA), .Xcs(xcsA), .Z(zA), .Bz(bzA), .cycles(cycA), .done(doneA)
  );

  // Instances B (CORR=1, NC=0, TW=6) and C (CORR=1, NC=1, TW=7) share start/operands
  logic            startB = 1'b0;
  logic [1:0][5:0] bxB = '0;
  logic [2:0]      precB = '0, precC = '0;
  logic            busyB, doneB, zB, busyC, doneC, zC;
  logic [1:0]      xsB, xsC;
  logic [0:0]      xcsB, xcsC;
  logic [6:0]      bzB, cycB;
  logic [7:0]      bzC, cycC;
  assign zB = xsB[0] & xsB[1];
  assign zC = xsC[0] & xsC[1];

  pret_et #(.W(6), .N(2), .NC(0), .CORR(1)) dutB (
    .clk(clk), .rst(rst), .start(startB), .Bxs(bxB), .prec(precB), .busy(busyB),
    .Xs(xsB), .Xcs(xcsB), .Z(zB), .Bz(bzB), .cycles(cycB), .done(doneB)
  );

  pret_et #(.W(6), .N(2), .NC(1), .CORR(1)) dutC (
    .clk(clk), .rst(rst), .start(startB), .Bxs(bxB), .prec(precC), .busy(busyC),
    .Xs(xsC), .Xcs(xcsC), .Z(zC), .Bz(bzC), .cycles(cycC), .done(doneC)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int rev6(input int v);
    int r = 0;
    for (int b = 0; b < 6; b++) r |= ((v >> b) & 1) << (5 - b);
    return r;
  endfunction

  // Expected Xs for sample k: bit0 from operand 0, bit1 from operand 1
  function automatic int xs_exp(input int bx0, input int bx1, input int k, input int corr);
    int f0, f1, r;
    f0 = k & 63;
    f1 = (corr != 0) ? f0 : ((k >> 6) & 63);
    r = 0;
    if (bx0 > rev6(f0)) r += 1;
    if (bx1 > rev6(f1)) r += 2;
    return r;
  endfunction

  // Whole-job reference: first sample count at which the top P bits can no longer move
  task automatic ref_run(input int corr, input int tw, input int bx0, input int bx1, input int p,
                         output int k, output int bz);
    int pc, s, full;
    pc = (p < 1) ? 1 : ((p > tw) ? tw : p);
    s = tw - pc;
    full = 1 << tw;
    bz = 0;
    k = 0;
    do begin
      if (xs_exp(bx0, bx1, k, corr) == 3) bz++;
      k++;
    end while (!((k == full) || ((bz >> s) == ((bz + full - k) >> s))));
  endtask

  // Behavioural model of instance A
  int m_busy = 0, m_done = 0, m_bx0 = 0, m_bx1 = 0, m_p = 0, m_k = 0, m_bz = 0;

  always @(posedge clk or posedge rst) begin : mdl
    int nk, nbz, r, s, pa;
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_bx0 <= 0; m_bx1 <= 0; m_p <= 0; m_k <= 0; m_bz <= 0;
    end else if (m_busy == 0 && startA) begin
      pa = int'(precA);
      m_busy <= 1; m_done <= 0;
      m_bx0 <= int'(bxA[0]); m_bx1 <= int'(bxA[1]);
      m_p <= (pa == 0) ? 1 : ((pa > 12) ? 12 : pa);
      m_k <= 0; m_bz <= 0;
    end else if (m_busy != 0) begin
      nk = m_k + 1;
      nbz = m_bz + ((xs_exp(m_bx0, m_bx1, m_k, 0) == 3) ? 1 : 0);
      r = 4096 - nk;
      s = 12 - m_p;
      m_k <= nk;
      m_bz <= nbz;
      if (r == 0 || (nbz >> s) == ((nbz + r) >> s)) begin
        m_busy <= 0; m_done <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("A_busy", int'(busyA), m_busy);
      chk("A_done", int'(doneA), m_done);
      chk("A_Bz", int'(bzA), m_bz);
      chk("A_cycles", int'(cycA), m_k);
      chk("A_Xs", int'(xsA), (m_busy != 0) ? xs_exp(m_bx0, m_bx1, m_k, 0) : 0);
      chk("A_Xcs", int'(xcsA), 0);
    end
  end

  task automatic jobA(input int b0, input int b1, input int p);
    @(negedge clk);
    bxA[0] = 6'(b0);
    bxA[1] = 6'(b1);
    precA  = 4'(p);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
  endtask

  task automatic wait_doneA(input int limit);
    int n = 0;
    while (!doneA && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!doneA) chk("A_done_timeout", int'(doneA), 1);
  endtask

  task automatic check_job(input string tag, input int b0, input int b1, input int p);
    int k, bz;
    ref_run(0, 12, b0, b1, p, k, bz);
    chk({tag, "_cycles"}, int'(cycA), k);
    chk({tag, "_Bz"}, int'(bzA), bz);
    chk({tag, "_done"}, int'(doneA), 1);
  endtask

  initial begin
    int n, k, bz, b0, b1, p;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(busyA), 0);
    chk("rst_done", int'(doneA), 0);
    chk("rst_Bz", int'(bzA), 0);
    chk("rst_Xs", int'(xsA), 0);

    // Pin the reference model with hand-derived values
    ref_run(0, 12, 16, 40, 12, k, bz);
    chk("ref_full_k", k, 4096);
    chk("ref_full_bz", bz, 640);
    ref_run(0, 12, 0, 40, 1, k, bz);
    chk("ref_zero_k", k, 2049);
    chk("ref_zero_bz", bz, 0);

    // Full-length run
    jobA(16, 40, 12);
    chk("t1_busy_start", int'(busyA), 1);
    n = 0;
    while (busyA && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("t1_busy_len", n, 4096);
    chk("t1_Bz", int'(bzA), 640);
    chk("t1_cycles", int'(cycA), 4096);
    chk("t1_done", int'(doneA), 1);
    chk("t1_Xs_after", int'(xsA), 0);

    // Early termination at P=4
    jobA(16, 40, 4);
    wait_doneA(5000);
    check_job("t2", 16, 40, 4);
    chk("t2_top_bits", int'(bzA) >> 8, 2);
    chk("t2_le_full", (int'(cycA) <= 4096) ? 1 : 0, 1);

    // Zero operand, P=1
    jobA(0, 40, 1);
    wait_doneA(5000);
    chk("t3_Bz", int'(bzA), 0);
    chk("t3_cycles", int'(cycA), 2049);

    // start mid-RUN is ignored
    jobA(16, 40, 10);
    repeat (50) @(negedge clk);
    bxA[0] = 6'(63); bxA[1] = 6'(63); precA = 4'(12); startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    wait_doneA(5000);
    check_job("t4", 16, 40, 10);

    // start in DONE launches a new job and drops done on the accepting edge
    jobA(33, 50, 5);
    chk("t5_done_drop", int'(doneA), 0);
    chk("t5_busy", int'(busyA), 1);
    wait_doneA(5000);
    check_job("t5", 33, 50, 5);

    // Asynchronous reset mid-run
    jobA(16, 40, 12);
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_Bz", int'(bzA), 0);
    chk("t6_cycles", int'(cycA), 0);
    chk("t6_Xs", int'(xsA), 0);
    chk("t6_busy", int'(busyA), 0);
    chk("t6_done", int'(doneA), 0);
    @(negedge clk);
    rst = 1'b0;
    jobA(16, 40, 12);
    wait_doneA(5000);
    chk("t6_rerun_Bz", int'(bzA), 640);
    chk("t6_rerun_cycles", int'(cycA), 4096);

    // Randomized jobs, including out-of-range and zero precision
    for (int j = 0; j < 6; j++) begin
      b0 = int'($urandom_range(63, 0));
      b1 = int'($urandom_range(63, 0));
      p  = int'($urandom_range(15, 0));
      jobA(b0, b1, p);
      wait_doneA(5000);
      check_job("rnd", b0, b1, p);
    end

    // Correlated instances
    ref_run(1, 6, 16, 40, 6, k, bz);
    chk("refB_k", k, 64);
    chk("refB_bz", bz, 16);
    ref_run(1, 7, 16, 40, 7, k, bz);
    chk("refC_k", k, 128);
    chk("refC_bz", bz, 32);

    @(negedge clk);
    bxB[0] = 6'(16); bxB[1] = 6'(40); precB = 3'(6); precC = 3'(7); startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    for (int s = 0; s < 128; s++) begin
      chk("C_Xcs", int'(xcsC), (s >> 6) & 1);
      chk("B_Xs", int'(xsB), (s < 64) ? xs_exp(16, 40, s, 1) : 0);
      @(negedge clk);
    end
    chk("B_done", int'(doneB), 1);
    chk("B_Bz", int'(bzB), 16);
    chk("B_cycles", int'(cycB), 64);
    chk("C_done", int'(doneC), 1);
    chk("C_Bz", int'(bzC), 32);
    chk("C_cycles", int'(cycC), 128);
    chk("C_Xcs_after", int'(xcsC), 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
